// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch (i_*), load/store (d_*) and memory (m_*) channels.
// The arbiter uses the slave view; the surrounding pipeline/memory side uses the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
);
  localparam int STRB_BITS = DATA_BITS / 8;

  logic                 i_avalid;
  logic [ADDR_BITS-1:0] i_addr;
  logic                 i_aready;
  logic                 i_flush;
  logic                 i_valid;
  logic [DATA_BITS-1:0] i_data;

  logic                 d_avalid;
  logic                 d_we;
  logic [ADDR_BITS-1:0] d_addr;
  logic [DATA_BITS-1:0] d_wdata;
  logic [STRB_BITS-1:0] d_wstrb;
  logic                 d_aready;
  logic                 d_valid;
  logic [DATA_BITS-1:0] d_rdata;

  logic                 m_avalid;
  logic                 m_we;
  logic [ADDR_BITS-1:0] m_addr;
  logic [DATA_BITS-1:0] m_wdata;
  logic [STRB_BITS-1:0] m_wstrb;
  logic                 m_aready;
  logic                 m_valid;
  logic [DATA_BITS-1:0] m_rdata;

  modport slave (
    input  i_avalid, i_addr, i_flush,
    output i_aready, i_valid, i_data,
    input  d_avalid, d_we, d_addr, d_wdata, d_wstrb,
    output d_aready, d_valid, d_rdata,
    output m_avalid, m_we, m_addr, m_wdata, m_wstrb,
    input  m_aready, m_valid, m_rdata
  );

  modport master (
    output i_avalid, i_addr, i_flush,
    input  i_aready, i_valid, i_data,
    output d_avalid, d_we, d_addr, d_wdata, d_wstrb,
    input  d_aready, d_valid, d_rdata,
    input  m_avalid, m_we, m_addr, m_wdata, m_wstrb,
    output m_aready, m_valid, m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between fetch (I) and load/store (D) with a single
// outstanding memory transaction; a fetch flush discards the in-flight instruction response.
module mem_port_arbiter #(
  parameter int ADDR_BITS  = 32,
  parameter int DATA_BITS  = 32,
  parameter int D_PRIORITY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int STRB_BITS = DATA_BITS / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT_I = 2'd1;
  localparam logic [1:0] WAIT_D = 2'd2;
  localparam logic [1:0] DROP_I = 2'd3;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic       last_grant_r;
  logic       last_grant_nxt_s;
  logic       grant_s;
  logic       req_s;
  logic       accept_s;

  // Pick the requester that owns the bus this cycle (only meaningful in IDLE)
  always_comb begin
    grant_s = GRANT_I;
    if (bus.d_avalid && bus.i_avalid) begin
      if (D_PRIORITY != 0) begin
        grant_s = GRANT_D;
      end else begin
        grant_s = ~last_grant_r;
      end
    end else if (bus.d_avalid) begin
      grant_s = GRANT_D;
    end else begin
      grant_s = GRANT_I;
    end
  end

  // Address phase is only open in IDLE; rst_n gating keeps the bus quiet while reset is held
  assign req_s    = rst_n && (state_r == IDLE) && (bus.i_avalid || bus.d_avalid);
  assign accept_s = req_s && bus.m_aready;

  // Memory-side payload mux and requester handshakes
  always_comb begin
    bus.m_avalid = req_s;
    bus.i_aready = accept_s && (grant_s == GRANT_I);
    bus.d_aready = accept_s && (grant_s == GRANT_D);
    if (req_s && (grant_s == GRANT_D)) begin
      bus.m_we    = bus.d_we;
      bus.m_addr  = bus.d_addr;
      bus.m_wdata = bus.d_wdata;
      bus.m_wstrb = bus.d_wstrb;
    end else if (req_s) begin
      bus.m_we    = 1'b0;
      bus.m_addr  = bus.i_addr;
      bus.m_wdata = {DATA_BITS{1'b0}};
      bus.m_wstrb = {STRB_BITS{1'b0}};
    end else begin
      bus.m_we    = 1'b0;
      bus.m_addr  = {ADDR_BITS{1'b0}};
      bus.m_wdata = {DATA_BITS{1'b0}};
      bus.m_wstrb = {STRB_BITS{1'b0}};
    end
  end

  // Response routing: a flush in the same cycle as the response suppresses the fetch pulse
  always_comb begin
    bus.i_valid = rst_n && (state_r == WAIT_I) && bus.m_valid && !bus.i_flush;
    bus.d_valid = rst_n && (state_r == WAIT_D) && bus.m_valid;
    bus.i_data  = bus.m_rdata;
    bus.d_rdata = bus.m_rdata;
  end

  // Transaction FSM and round-robin history
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s      = (grant_s == GRANT_D) ? WAIT_D : WAIT_I;
          last_grant_nxt_s = grant_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_I: begin
        if (bus.m_valid) begin
          state_nxt_s = IDLE;
        end else if (bus.i_flush) begin
          state_nxt_s = DROP_I;
        end else begin
          state_nxt_s = WAIT_I;
        end
      end
      WAIT_D: begin
        if (bus.m_valid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_D;
        end
      end
      DROP_I: begin
        if (bus.m_valid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DROP_I;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= GRANT_D;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected grants/responses into queues,
// a negedge monitor pops and compares whenever a DUT accepts a request or pulses a valid.
module tb_mem_port_arbiter;
  typedef struct packed {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } grant_t;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } resp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  grant_t gq[2][$];
  resp_t  rq[2][$];

  mem_port_arbiter_if #(.ADDR_BITS(32), .DATA_BITS(32)) bp ();
  mem_port_arbiter_if #(.ADDR_BITS(32), .DATA_BITS(32)) br ();

  mem_port_arbiter #(.ADDR_BITS(32), .DATA_BITS(32), .D_PRIORITY(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .bus(bp)
  );
  mem_port_arbiter #(.ADDR_BITS(32), .DATA_BITS(32), .D_PRIORITY(0)) dut_r (
    .clk(clk), .rst_n(rst_n), .bus(br)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic pg(input int u, input logic is_d, input logic we, input logic [31:0] a,
                    input logic [31:0] wd, input logic [3:0] ws);
    grant_t g;
    g = {is_d, we, a, wd, ws};
    gq[u].push_back(g);
  endtask

  task automatic pr(input int u, input logic is_d, input logic [31:0] d);
    resp_t r;
    r = {is_d, d};
    rq[u].push_back(r);
  endtask

  task automatic mon(input int u, input logic acc, input logic ia, input logic da,
                     input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input logic iv, input logic dv,
                     input logic [31:0] idat, input logic [31:0] ddat);
    grant_t g;
    grant_t e;
    resp_t  r;
    resp_t  er;
    if (acc) begin
      g = {da, we, a, wd, ws};
      if (gq[u].size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_grant dut%0d actual=%h expected=none", u, g);
      end else begin
        e = gq[u].pop_front();
        check($sformatf("grant_dut%0d", u), 70'(g), 70'(e));
        check($sformatf("aready_pair_dut%0d", u), 70'({ia, da}), 70'({~e.is_d, e.is_d}));
      end
    end
    if (iv || dv) begin
      r = {dv, (dv ? ddat : idat)};
      if ((iv && dv) || rq[u].size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid dut%0d actual=iv%0b dv%0b data=%h expected=none", u, iv, dv, r.data);
      end else begin
        er = rq[u].pop_front();
        check($sformatf("resp_dut%0d", u), 70'(r), 70'(er));
      end
    end
  endtask

  // Scoreboard monitor for both arbiters
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, bp.m_avalid & bp.m_aready, bp.i_aready, bp.d_aready, bp.m_we, bp.m_addr,
          bp.m_wdata, bp.m_wstrb, bp.i_valid, bp.d_valid, bp.i_data, bp.d_rdata);
      mon(1, br.m_avalid & br.m_aready, br.i_aready, br.d_aready, br.m_we, br.m_addr,
          br.m_wdata, br.m_wstrb, br.i_valid, br.d_valid, br.i_data, br.d_rdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bp.i_avalid = 1'b0; bp.i_addr = 32'h0; bp.i_flush = 1'b0;
    bp.d_avalid = 1'b0; bp.d_we = 1'b0; bp.d_addr = 32'h0; bp.d_wdata = 32'h0; bp.d_wstrb = 4'h0;
    bp.m_aready = 1'b0; bp.m_valid = 1'b0; bp.m_rdata = 32'h0;
    br.i_avalid = 1'b0; br.i_addr = 32'h0; br.i_flush = 1'b0;
    br.d_avalid = 1'b0; br.d_we = 1'b0; br.d_addr = 32'h0; br.d_wdata = 32'h0; br.d_wstrb = 4'h0;
    br.m_aready = 1'b0; br.m_valid = 1'b0; br.m_rdata = 32'h0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear_inputs();
    // Reset: requests pending but everything must stay quiet
    bp.i_avalid = 1'b1; bp.d_avalid = 1'b1; bp.m_aready = 1'b1;
    br.i_avalid = 1'b1; br.m_aready = 1'b1;
    #3;
    check("rst_outs_p", 70'({bp.m_avalid, bp.i_aready, bp.d_aready, bp.i_valid, bp.d_valid}), 70'(0));
    check("rst_outs_r", 70'({br.m_avalid, br.i_aready, br.d_aready, br.i_valid, br.d_valid}), 70'(0));
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", 70'({bp.m_avalid, br.m_avalid}), 70'(0));

    // Round-robin: both held high, grants I,D,I,D
    cyc();
    br.i_avalid = 1'b1; br.i_addr = 32'h800;
    br.d_avalid = 1'b1; br.d_we = 1'b0; br.d_addr = 32'h900; br.m_aready = 1'b1;
    pg(1, 1'b0, 1'b0, 32'h800, 32'h0, 4'h0);
    pg(1, 1'b1, 1'b0, 32'h900, 32'h0, 4'h0);
    pg(1, 1'b0, 1'b0, 32'h800, 32'h0, 4'h0);
    pg(1, 1'b1, 1'b0, 32'h900, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      pr(1, k[0], 32'h1000 + 32'(k));
      @(negedge clk);
      check("rr_turn", 70'({br.i_aready, br.d_aready}), 70'({~k[0], k[0]}));
      cyc();
      cyc();
      br.m_valid = 1'b1; br.m_rdata = 32'h1000 + 32'(k);
      cyc();
      br.m_valid = 1'b0; br.m_rdata = 32'h0;
      if (k == 3) begin
        br.i_avalid = 1'b0; br.d_avalid = 1'b0; br.m_aready = 1'b0;
      end
    end

    // Single fetch, response two cycles after acceptance
    cyc();
    bp.i_avalid = 1'b1; bp.i_addr = 32'h100; bp.m_aready = 1'b1;
    pg(0, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
    pr(0, 1'b0, 32'h13);
    @(negedge clk);
    check("t1_aready", 70'(bp.i_aready), 70'(1));
    cyc();
    bp.i_avalid = 1'b0; bp.m_aready = 1'b0;
    cyc();
    bp.m_valid = 1'b1; bp.m_rdata = 32'h13;
    @(negedge clk);
    check("t1_ivalid", 70'(bp.i_valid), 70'(1));
    cyc();
    bp.m_valid = 1'b0; bp.m_rdata = 32'h0;

    // Tie with D priority: D store first, I stalls then wins
    bp.i_avalid = 1'b1; bp.i_addr = 32'h104;
    bp.d_avalid = 1'b1; bp.d_we = 1'b1; bp.d_addr = 32'h200;
    bp.d_wdata = 32'hDEADBEEF; bp.d_wstrb = 4'hF; bp.m_aready = 1'b1;
    pg(0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'hF);
    pg(0, 1'b0, 1'b0, 32'h104, 32'h0, 4'h0);
    pr(0, 1'b1, 32'h0);
    pr(0, 1'b0, 32'h20000093);
    @(negedge clk);
    check("t2_d_first", 70'({bp.d_aready, bp.i_aready}), 70'(2'b10));
    cyc();
    bp.d_avalid = 1'b0; bp.d_we = 1'b0; bp.d_wdata = 32'h0; bp.d_wstrb = 4'h0;
    @(negedge clk);
    check("t2_stall", 70'({bp.m_avalid, bp.i_aready}), 70'(0));
    cyc();
    bp.m_valid = 1'b1;
    @(negedge clk);
    check("t2_dvalid", 70'({bp.d_valid, bp.i_valid}), 70'(2'b10));
    cyc();
    bp.m_valid = 1'b0;
    @(negedge clk);
    check("t2_i_second", 70'(bp.i_aready), 70'(1));
    cyc();
    bp.i_avalid = 1'b0; bp.m_aready = 1'b0;
    cyc();
    bp.m_valid = 1'b1; bp.m_rdata = 32'h20000093;
    cyc();
    bp.m_valid = 1'b0; bp.m_rdata = 32'h0;

    // Flush one cycle after acceptance, response three cycles after
    bp.i_avalid = 1'b1; bp.i_addr = 32'h180; bp.m_aready = 1'b1;
    pg(0, 1'b0, 1'b0, 32'h180, 32'h0, 4'h0);
    cyc();
    bp.i_avalid = 1'b0; bp.m_aready = 1'b0; bp.i_flush = 1'b1;
    cyc();
    bp.i_flush = 1'b0;
    cyc();
    bp.m_valid = 1'b1; bp.m_rdata = 32'hBAD;
    bp.i_avalid = 1'b1; bp.i_addr = 32'h300; bp.m_aready = 1'b1;
    @(negedge clk);
    check("t4_dropped", 70'({bp.i_valid, bp.i_aready, bp.m_avalid}), 70'(0));
    cyc();
    bp.m_valid = 1'b0; bp.m_rdata = 32'h0;
    pg(0, 1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
    pr(0, 1'b0, 32'h37);
    @(negedge clk);
    check("t4_refetch", 70'(bp.i_aready), 70'(1));
    cyc();
    bp.i_avalid = 1'b0; bp.m_aready = 1'b0;
    cyc();
    bp.m_valid = 1'b1; bp.m_rdata = 32'h37;
    cyc();
    bp.m_valid = 1'b0; bp.m_rdata = 32'h0;

    // Flush coincident with the response
    bp.i_avalid = 1'b1; bp.i_addr = 32'h400; bp.m_aready = 1'b1;
    pg(0, 1'b0, 1'b0, 32'h400, 32'h0, 4'h0);
    cyc();
    bp.i_avalid = 1'b0; bp.m_aready = 1'b0;
    cyc();
    bp.m_valid = 1'b1; bp.m_rdata = 32'h55; bp.i_flush = 1'b1;
    @(negedge clk);
    check("t5_no_ivalid", 70'(bp.i_valid), 70'(0));
    cyc();
    // Back in IDLE; a flush here must not block the redirect fetch
    bp.m_valid = 1'b0; bp.m_rdata = 32'h0;
    bp.i_avalid = 1'b1; bp.i_addr = 32'h500; bp.m_aready = 1'b1;
    pg(0, 1'b0, 1'b0, 32'h500, 32'h0, 4'h0);
    pr(0, 1'b0, 32'h66);
    @(negedge clk);
    check("t5_flush_idle_fetch", 70'(bp.i_aready), 70'(1));
    cyc();
    bp.i_flush = 1'b0; bp.i_avalid = 1'b0; bp.m_aready = 1'b0;
    cyc();
    bp.m_valid = 1'b1; bp.m_rdata = 32'h66;
    cyc();
    bp.m_valid = 1'b0; bp.m_rdata = 32'h0;
    cyc();
    bp.m_valid = 1'b1; bp.m_rdata = 32'h99;
    @(negedge clk);
    check("stray_mvalid", 70'({bp.i_valid, bp.d_valid}), 70'(0));
    cyc();
    bp.m_valid = 1'b0; bp.m_rdata = 32'h0;

    // Reset while waiting on a load
    bp.d_avalid = 1'b1; bp.d_we = 1'b0; bp.d_addr = 32'h600; bp.m_aready = 1'b1;
    pg(0, 1'b1, 1'b0, 32'h600, 32'h0, 4'h0);
    @(negedge clk);
    check("t6_load_acc", 70'(bp.d_aready), 70'(1));
    cyc();
    bp.d_avalid = 1'b0; bp.i_avalid = 1'b1; bp.i_addr = 32'h700;
    bp.m_valid = 1'b1; bp.m_rdata = 32'h77;
    #1;
    check("t6_pre_rst_dvalid", 70'(bp.d_valid), 70'(1));
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_outs", 70'({bp.m_avalid, bp.i_aready, bp.d_aready, bp.i_valid, bp.d_valid,
                             bp.m_we, bp.m_addr, bp.m_wstrb}), 70'(0));
    cyc();
    bp.m_valid = 1'b0; bp.m_rdata = 32'h0;
    cyc();
    pg(0, 1'b0, 1'b0, 32'h700, 32'h0, 4'h0);
    pr(0, 1'b0, 32'h71);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_idle_after", 70'(bp.i_aready), 70'(1));
    cyc();
    bp.i_avalid = 1'b0; bp.m_aready = 1'b0;
    cyc();
    bp.m_valid = 1'b1; bp.m_rdata = 32'h71;
    cyc();
    bp.m_valid = 1'b0; bp.m_rdata = 32'h0;
    repeat (3) cyc();

    check("left_grants_p", 70'(gq[0].size()), 70'(0));
    check("left_resps_p", 70'(rq[0].size()), 70'(0));
    check("left_grants_r", 70'(gq[1].size()), 70'(0));
    check("left_resps_r", 70'(rq[1].size()), 70'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
